// File: rtl/vrampx_blitter.sv
// vrampx_blitter: rectangle fill/copy engine driving the VRAMPX CPU port.
// Pixels are visited in ascending raster order, one command at a time. All outputs are registered.
// Optional feature macro: VRAMPX_BLITTER_COPY_EN compiles in the copy path
// (C_RD/C_WAIT/C_WR states, src_x_i/src_y_i/vram_q_i). Without it, op=1 commands are rejected.

module vrampx_blitter #(
    parameter int unsigned FB_WIDTH  = 320,
    parameter int unsigned FB_HEIGHT = 240,
    parameter int unsigned ADDR_BITS = 17
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 start_i,
    input  logic                 op_i,
    input  logic [8:0]           dst_x_i,
    input  logic [7:0]           dst_y_i,
    input  logic [8:0]           src_x_i,
    input  logic [7:0]           src_y_i,
    input  logic [8:0]           width_i,
    input  logic [7:0]           height_i,
    input  logic [7:0]           color_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic [ADDR_BITS-1:0] vram_addr_o,
    output logic [7:0]           vram_d_o,
    output logic                 vram_we_o,
    input  logic [7:0]           vram_q_i
);

    localparam logic [ADDR_BITS-1:0] RowStride = ADDR_BITS'(FB_WIDTH);
    localparam logic [ADDR_BITS-1:0] AddrOne   = ADDR_BITS'(1);

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StCRd,
        StCWait,
        StCWr,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic                 we_q, we_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [7:0]           wdata_q, wdata_d;
    logic [8:0]           w_q, w_d;
    logic [7:0]           h_q, h_d;
    logic [8:0]           col_q, col_d;
    logic [7:0]           row_q, row_d;
    logic [ADDR_BITS-1:0] dst_row_q, dst_row_d;
    logic [ADDR_BITS-1:0] dst_ptr_q, dst_ptr_d;

    // Command validation and row-base computation on the raw inputs, used only at acceptance.
    logic [9:0]           dst_x_end;
    logic [8:0]           dst_y_end;
    logic                 dst_oob;
    logic                 cmd_bad;
    logic [ADDR_BITS-1:0] dst_base;

    assign dst_x_end = {1'b0, dst_x_i} + {1'b0, width_i};
    assign dst_y_end = {1'b0, dst_y_i} + {1'b0, height_i};
    assign dst_oob   = (32'(dst_x_end) > FB_WIDTH) || (32'(dst_y_end) > FB_HEIGHT);
    assign dst_base  = ADDR_BITS'(dst_y_i) * RowStride + ADDR_BITS'(dst_x_i);

    // Raster stepping: end of row jumps to the next row base, otherwise +1.
    logic                 row_end;
    logic                 last_px;
    logic [ADDR_BITS-1:0] dst_next;

    assign row_end  = (col_q == w_q - 9'd1);
    assign last_px  = row_end && (row_q == h_q - 8'd1);
    assign dst_next = row_end ? dst_row_q + RowStride : dst_ptr_q + AddrOne;

`ifdef VRAMPX_BLITTER_COPY_EN
    logic [ADDR_BITS-1:0] src_row_q, src_row_d;
    logic [ADDR_BITS-1:0] src_ptr_q, src_ptr_d;
    logic [9:0]           src_x_end;
    logic [8:0]           src_y_end;
    logic                 src_oob;
    logic [ADDR_BITS-1:0] src_base;
    logic [ADDR_BITS-1:0] src_next;

    assign src_x_end = {1'b0, src_x_i} + {1'b0, width_i};
    assign src_y_end = {1'b0, src_y_i} + {1'b0, height_i};
    assign src_oob   = (32'(src_x_end) > FB_WIDTH) || (32'(src_y_end) > FB_HEIGHT);
    assign src_base  = ADDR_BITS'(src_y_i) * RowStride + ADDR_BITS'(src_x_i);
    assign src_next  = row_end ? src_row_q + RowStride : src_ptr_q + AddrOne;
    assign cmd_bad   = (width_i == 9'd0) || (height_i == 8'd0) || dst_oob || (op_i && src_oob);
`else
    // Copy is not built: any op=1 command is rejected and the copy inputs are left unused.
    logic unused_copy_inputs;
    assign unused_copy_inputs = ^{src_x_i, src_y_i, vram_q_i};
    assign cmd_bad = (width_i == 9'd0) || (height_i == 8'd0) || dst_oob || op_i;
`endif

    // State register and all registered outputs; reset abandons any command in flight.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            w_q       <= '0;
            h_q       <= '0;
            col_q     <= '0;
            row_q     <= '0;
            dst_row_q <= '0;
            dst_ptr_q <= '0;
`ifdef VRAMPX_BLITTER_COPY_EN
            src_row_q <= '0;
            src_ptr_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            w_q       <= w_d;
            h_q       <= h_d;
            col_q     <= col_d;
            row_q     <= row_d;
            dst_row_q <= dst_row_d;
            dst_ptr_q <= dst_ptr_d;
`ifdef VRAMPX_BLITTER_COPY_EN
            src_row_q <= src_row_d;
            src_ptr_q <= src_ptr_d;
`endif
        end
    end

    // Next-state logic: outputs are computed one cycle ahead so they leave the block registered.
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = error_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        w_d       = w_q;
        h_d       = h_q;
        col_d     = col_q;
        row_d     = row_q;
        dst_row_d = dst_row_q;
        dst_ptr_d = dst_ptr_q;
`ifdef VRAMPX_BLITTER_COPY_EN
        src_row_d = src_row_q;
        src_ptr_d = src_ptr_q;
`endif

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    busy_d = 1'b1;
                    w_d    = width_i;
                    h_d    = height_i;
                    col_d  = '0;
                    row_d  = '0;
                    if (cmd_bad) begin
                        error_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        error_d   = 1'b0;
                        dst_row_d = dst_base;
                        dst_ptr_d = dst_base;
`ifdef VRAMPX_BLITTER_COPY_EN
                        if (op_i) begin
                            src_row_d = src_base;
                            src_ptr_d = src_base;
                            addr_d    = src_base;
                            we_d      = 1'b0;
                            state_d   = StCRd;
                        end else begin
                            addr_d  = dst_base;
                            wdata_d = color_i;
                            we_d    = 1'b1;
                            state_d = StFill;
                        end
`else
                        addr_d  = dst_base;
                        wdata_d = color_i;
                        we_d    = 1'b1;
                        state_d = StFill;
`endif
                    end
                end
            end

            // One write per cycle; wdata holds the colour latched at acceptance.
            StFill: begin
                if (last_px) begin
                    we_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    col_d     = row_end ? 9'd0 : col_q + 9'd1;
                    row_d     = row_end ? row_q + 8'd1 : row_q;
                    dst_row_d = row_end ? dst_next : dst_row_q;
                    dst_ptr_d = dst_next;
                    addr_d    = dst_next;
                end
            end

`ifdef VRAMPX_BLITTER_COPY_EN
            // Source address was presented during C_RD; the RAM answers during C_WAIT.
            StCRd: begin
                state_d = StCWait;
            end

            StCWait: begin
                addr_d  = dst_ptr_q;
                wdata_d = vram_q_i;
                we_d    = 1'b1;
                state_d = StCWr;
            end

            StCWr: begin
                we_d = 1'b0;
                if (last_px) begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    col_d     = row_end ? 9'd0 : col_q + 9'd1;
                    row_d     = row_end ? row_q + 8'd1 : row_q;
                    dst_row_d = row_end ? dst_next : dst_row_q;
                    dst_ptr_d = dst_next;
                    src_row_d = row_end ? src_next : src_row_q;
                    src_ptr_d = src_next;
                    addr_d    = src_next;
                    state_d   = StCRd;
                end
            end
`endif

            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end

            default: begin
                busy_d  = 1'b0;
                we_d    = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign error_o     = error_q;
    assign vram_we_o   = we_q;
    assign vram_addr_o = addr_q;
    assign vram_d_o    = wdata_q;

endmodule
